mem_port_arbiter: RTL and testbench

//  Shares the single backing-memory port between the instruction cache (client 0) and data cache (client 1).

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one memory port between two cache clients with ID-routed responses
module mem_port_arbiter #(
  parameter int N_BYTES  = 16,
  parameter int PA_WIDTH = 32,
  parameter int ID_WIDTH = 4,
  parameter int Q_DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_c0_enable,
  input  logic                    i_c0_type,
  input  logic [PA_WIDTH-1:0]     i_c0_addr,
  input  logic [N_BYTES*8-1:0]    i_c0_data,
  output logic [ID_WIDTH-1:0]     o_c0_id_request,
  output logic                    o_c0_full,
  output logic                    o_c0_mem_enable,
  input  logic                    i_c0_mem_ack,
  input  logic                    i_c1_enable,
  input  logic                    i_c1_type,
  input  logic [PA_WIDTH-1:0]     i_c1_addr,
  input  logic [N_BYTES*8-1:0]    i_c1_data,
  output logic [ID_WIDTH-1:0]     o_c1_id_request,
  output logic                    o_c1_full,
  output logic                    o_c1_mem_enable,
  input  logic                    i_c1_mem_ack,
  output logic [N_BYTES*8-1:0]    o_c_mem_data,
  output logic [ID_WIDTH-1:0]     o_c_mem_id_response,
  output logic                    o_mem_enable,
  output logic                    o_mem_type,
  output logic [PA_WIDTH-1:0]     o_mem_addr,
  output logic [N_BYTES*8-1:0]    o_mem_data,
  output logic [ID_WIDTH-1:0]     o_mem_id,
  input  logic                    i_mem_ready,
  input  logic                    i_mem_enable,
  input  logic [N_BYTES*8-1:0]    i_mem_data,
  input  logic [ID_WIDTH-1:0]     i_mem_id,
  output logic                    o_mem_ack,
  output logic                    o_overflow
);
  localparam int LW = N_BYTES * 8;
  localparam int SW = ID_WIDTH - 1;
  localparam int AW = $clog2(Q_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {ISSUE_IDLE, ISSUE_BUSY} state_t;
  state_t r_state;
  logic [1:0] w_en, w_ty, w_av, w_pop, w_acc, w_full, w_ht;
  logic [PA_WIDTH-1:0] w_ad [2];
  logic [LW-1:0] w_dt [2];
  logic [PA_WIDTH-1:0] w_ha [2];
  logic [LW-1:0] w_hd [2];
  logic [ID_WIDTH-1:0] w_hi [2];
  logic [ID_WIDTH-1:0] w_nid [2];
  logic r_qt [2][Q_DEPTH];
  logic [PA_WIDTH-1:0] r_qa [2][Q_DEPTH];
  logic [LW-1:0] r_qd [2][Q_DEPTH];
  logic [ID_WIDTH-1:0] r_qi [2][Q_DEPTH];
  logic [AW-1:0] r_rd [2];
  logic [AW-1:0] r_wr [2];
  logic [CW-1:0] r_cnt [2];
  logic [SW-1:0] r_seq [2];
  logic r_rr, r_overflow, r_mem_enable, r_mem_type;
  logic [PA_WIDTH-1:0] r_mem_addr;
  logic [LW-1:0] r_mem_data;
  logic [ID_WIDTH-1:0] r_mem_id;
  logic w_win, w_issue, w_owner;
  assign w_en = {i_c1_enable, i_c0_enable};
  assign w_ty = {i_c1_type, i_c0_type};
  assign w_ad = '{i_c0_addr, i_c1_addr};
  assign w_dt = '{i_c0_data, i_c1_data};
  // Queue heads; an empty queue presents the incoming request so it can issue in the same cycle
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_nid[c] = {c[0], r_seq[c]};
      w_av[c]  = r_cnt[c] != '0 || w_en[c];
      w_full[c] = r_cnt[c] == CW'(Q_DEPTH);
      w_ht[c]  = r_cnt[c] != '0 ? r_qt[c][r_rd[c]] : w_ty[c];
      w_ha[c]  = r_cnt[c] != '0 ? r_qa[c][r_rd[c]] : w_ad[c];
      w_hd[c]  = r_cnt[c] != '0 ? r_qd[c][r_rd[c]] : w_dt[c];
      w_hi[c]  = r_cnt[c] != '0 ? r_qi[c][r_rd[c]] : w_nid[c];
    end
  end
  assign w_win   = &w_av ? r_rr : w_av[1];
  assign w_issue = (r_state == ISSUE_IDLE || i_mem_ready) && |w_av;
  assign w_pop   = {w_issue && w_win, w_issue && !w_win};
  assign w_acc   = w_en & (~w_full | w_pop);
  // Per-client request FIFOs, sequence counters and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        r_rd[c]  <= '0;
        r_wr[c]  <= '0;
        r_cnt[c] <= '0;
        r_seq[c] <= '0;
      end
      r_overflow <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (w_acc[c]) begin
          r_qt[c][r_wr[c]] <= w_ty[c];
          r_qa[c][r_wr[c]] <= w_ad[c];
          r_qd[c][r_wr[c]] <= w_dt[c];
          r_qi[c][r_wr[c]] <= w_nid[c];
          r_wr[c]  <= r_wr[c] + AW'(1);
          r_seq[c] <= r_seq[c] + SW'(!w_ty[c]);
        end
        if (w_pop[c]) r_rd[c] <= r_rd[c] + AW'(1);
        r_cnt[c] <= r_cnt[c] + CW'(w_acc[c]) - CW'(w_pop[c]);
      end
      r_overflow <= r_overflow | |(w_en & ~w_acc);
    end
  end
  // Issue FSM: load the round-robin winner into the request registers, hold until memory accepts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ISSUE_IDLE;
      r_mem_enable <= 1'b0;
      r_mem_type   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_mem_id     <= '0;
      r_rr         <= 1'b0;
    end else if (w_issue) begin
      r_state      <= ISSUE_BUSY;
      r_mem_enable <= 1'b1;
      r_mem_type   <= w_ht[w_win];
      r_mem_addr   <= w_ha[w_win];
      r_mem_data   <= w_hd[w_win];
      r_mem_id     <= w_hi[w_win];
      r_rr         <= !w_win;
    end else if (r_state == ISSUE_BUSY && i_mem_ready) begin
      r_state      <= ISSUE_IDLE;
      r_mem_enable <= 1'b0;
    end
  end
  assign o_c0_id_request     = w_nid[0];
  assign o_c1_id_request     = w_nid[1];
  assign o_c0_full           = w_full[0];
  assign o_c1_full           = w_full[1];
  assign o_overflow          = r_overflow;
  assign o_mem_enable        = r_mem_enable;
  assign o_mem_type          = r_mem_type;
  assign o_mem_addr          = r_mem_addr;
  assign o_mem_data          = r_mem_data;
  assign o_mem_id            = r_mem_id;
  assign w_owner             = i_mem_id[ID_WIDTH-1];
  assign o_c0_mem_enable     = i_mem_enable && !w_owner;
  assign o_c1_mem_enable     = i_mem_enable && w_owner;
  assign o_mem_ack           = i_mem_enable && (w_owner ? i_c1_mem_ack : i_c0_mem_ack);
  assign o_c_mem_data        = i_mem_data;
  assign o_c_mem_id_response = i_mem_id;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and randomized checks of mem_port_arbiter against a queue-based model
module tb_mem_port_arbiter;
  localparam int QD = 2;
  typedef struct {
    logic         t;
    logic [31:0]  a;
    logic [127:0] d;
    logic [3:0]   id;
  } ent_t;
  logic clk = 1'b0, rst = 1'b1;
  logic i_c0_enable = 0, i_c0_type = 0, i_c0_mem_ack = 0;
  logic i_c1_enable = 0, i_c1_type = 0, i_c1_mem_ack = 0;
  logic [31:0] i_c0_addr = 0, i_c1_addr = 0;
  logic [127:0] i_c0_data = 0, i_c1_data = 0, i_mem_data = 0;
  logic i_mem_ready = 0, i_mem_enable = 0;
  logic [3:0] i_mem_id = 0;
  logic [3:0] o_c0_id_request, o_c1_id_request, o_c_mem_id_response, o_mem_id;
  logic o_c0_full, o_c1_full, o_c0_mem_enable, o_c1_mem_enable;
  logic o_mem_enable, o_mem_type, o_mem_ack, o_overflow;
  logic [127:0] o_c_mem_data, o_mem_data;
  logic [31:0] o_mem_addr;
  int n_vec = 0, n_err = 0;
  ent_t q0[$], q1[$], me;
  logic [2:0] seq0 = 0, seq1 = 0;
  logic rr = 0, men = 0, ovf = 0;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_c0_enable(i_c0_enable), .i_c0_type(i_c0_type), .i_c0_addr(i_c0_addr), .i_c0_data(i_c0_data),
    .o_c0_id_request(o_c0_id_request), .o_c0_full(o_c0_full), .o_c0_mem_enable(o_c0_mem_enable),
    .i_c0_mem_ack(i_c0_mem_ack),
    .i_c1_enable(i_c1_enable), .i_c1_type(i_c1_type), .i_c1_addr(i_c1_addr), .i_c1_data(i_c1_data),
    .o_c1_id_request(o_c1_id_request), .o_c1_full(o_c1_full), .o_c1_mem_enable(o_c1_mem_enable),
    .i_c1_mem_ack(i_c1_mem_ack),
    .o_c_mem_data(o_c_mem_data), .o_c_mem_id_response(o_c_mem_id_response),
    .o_mem_enable(o_mem_enable), .o_mem_type(o_mem_type), .o_mem_addr(o_mem_addr),
    .o_mem_data(o_mem_data), .o_mem_id(o_mem_id), .i_mem_ready(i_mem_ready),
    .i_mem_enable(i_mem_enable), .i_mem_data(i_mem_data), .i_mem_id(i_mem_id),
    .o_mem_ack(o_mem_ack), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model of one clock edge: arrivals join their FIFO, then the port takes the next request if free
  task automatic model_step();
    logic ne0, ne1, iss, w;
    if (rst) begin
      q0.delete(); q1.delete();
      seq0 = 0; seq1 = 0; rr = 0; men = 0; ovf = 0;
      return;
    end
    ne0 = q0.size() > 0 || i_c0_enable;
    ne1 = q1.size() > 0 || i_c1_enable;
    iss = (!men || i_mem_ready) && (ne0 || ne1);
    w = (ne0 && ne1) ? rr : ne1;
    if (i_c0_enable) begin
      if (q0.size() < QD || (iss && !w)) begin
        q0.push_back('{i_c0_type, i_c0_addr, i_c0_data, {1'b0, seq0}});
        if (!i_c0_type) seq0++;
      end else ovf = 1;
    end
    if (i_c1_enable) begin
      if (q1.size() < QD || (iss && w)) begin
        q1.push_back('{i_c1_type, i_c1_addr, i_c1_data, {1'b1, seq1}});
        if (!i_c1_type) seq1++;
      end else ovf = 1;
    end
    if (iss) begin
      if (w) me = q1.pop_front();
      else me = q0.pop_front();
      men = 1;
      rr = !w;
    end else if (i_mem_ready) men = 0;
  endtask

  task automatic check_model();
    logic own;
    own = i_mem_id[3];
    chk("mem_enable", o_mem_enable, men);
    if (men) begin
      chk("mem_type", o_mem_type, me.t);
      chk("mem_addr", o_mem_addr, me.a);
      chk("mem_data", o_mem_data, me.d);
      chk("mem_id", o_mem_id, me.id);
    end
    chk("c0_id_request", o_c0_id_request, {1'b0, seq0});
    chk("c1_id_request", o_c1_id_request, {1'b1, seq1});
    chk("c0_full", o_c0_full, q0.size() == QD);
    chk("c1_full", o_c1_full, q1.size() == QD);
    chk("overflow", o_overflow, ovf);
    chk("c0_mem_enable", o_c0_mem_enable, i_mem_enable && !own);
    chk("c1_mem_enable", o_c1_mem_enable, i_mem_enable && own);
    chk("mem_ack", o_mem_ack, i_mem_enable && (own ? i_c1_mem_ack : i_c0_mem_ack));
    chk("c_mem_data", o_c_mem_data, i_mem_data);
    chk("c_mem_id_response", o_c_mem_id_response, i_mem_id);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    i_c0_enable = 0; i_c1_enable = 0; i_c0_type = 0; i_c1_type = 0;
    i_mem_enable = 0; i_c0_mem_ack = 0; i_c1_mem_ack = 0; i_mem_id = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  initial begin
    do_reset();
    chk("rst c0_id_request", o_c0_id_request, 4'h0);
    chk("rst c1_id_request", o_c1_id_request, 4'h8);
    chk("rst mem_enable", o_mem_enable, 1'b0);
    chk("rst overflow", o_overflow, 1'b0);
    chk("rst c0_full", o_c0_full, 1'b0);
    // single c1 read issues on the next cycle with id 8
    i_mem_ready = 1;
    i_c1_enable = 1; i_c1_type = 0; i_c1_addr = 32'h100; i_c1_data = 128'h0;
    tick();
    chk("t1 mem_enable", o_mem_enable, 1'b1);
    chk("t1 mem_addr", o_mem_addr, 32'h100);
    chk("t1 mem_id", o_mem_id, 4'h8);
    chk("t1 c1_id_request", o_c1_id_request, 4'h9);
    idle_inputs();
    tick();
    // simultaneous reads: c0 then c1
    do_reset();
    i_mem_ready = 1;
    i_c0_enable = 1; i_c0_addr = 32'h40;
    i_c1_enable = 1; i_c1_addr = 32'h80;
    tick();
    chk("t2 first id", o_mem_id, 4'h0);
    idle_inputs();
    tick();
    chk("t2 second id", o_mem_id, 4'h8);
    chk("t2 second addr", o_mem_addr, 32'h80);
    tick();
    // write then read from c1 while memory stalls
    do_reset();
    i_mem_ready = 0;
    i_c1_enable = 1; i_c1_type = 1; i_c1_addr = 32'h200; i_c1_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA;
    tick();
    chk("t3 write type", o_mem_type, 1'b1);
    chk("t3 write id", o_mem_id, 4'h8);
    i_c1_type = 0; i_c1_addr = 32'h300;
    tick();
    idle_inputs();
    tick();
    chk("t3 held addr", o_mem_addr, 32'h200);
    chk("t3 held data", o_mem_data, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5555_AAAA);
    i_mem_ready = 1;
    tick();
    chk("t3 read addr", o_mem_addr, 32'h300);
    chk("t3 read type", o_mem_type, 1'b0);
    chk("t3 read id", o_mem_id, 4'h8);
    tick();
    // overflow: port busy, three c0 pushes into a two-entry queue
    do_reset();
    i_mem_ready = 0;
    i_c1_enable = 1; i_c1_addr = 32'h500;
    tick();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      i_c0_enable = 1; i_c0_addr = 32'h600 + 32'(k) * 16;
      tick();
      if (k == 1) chk("t4 full after two", o_c0_full, 1'b1);
    end
    idle_inputs();
    chk("t4 overflow", o_overflow, 1'b1);
    chk("t4 seq advanced two", o_c0_id_request, 4'h2);
    // response for c1 acked only by c0
    i_mem_enable = 1; i_mem_id = 4'h9; i_c0_mem_ack = 1; i_c1_mem_ack = 0;
    #1;
    chk("t5 ack ignored", o_mem_ack, 1'b0);
    chk("t5 c1 enable", o_c1_mem_enable, 1'b1);
    chk("t5 c0 enable", o_c0_mem_enable, 1'b0);
    i_c1_mem_ack = 1;
    #1;
    chk("t5 ack owner", o_mem_ack, 1'b1);
    idle_inputs();
    // reset while busy with two queued
    rst = 1;
    tick();
    chk("t6 mem_enable", o_mem_enable, 1'b0);
    chk("t6 c0_full", o_c0_full, 1'b0);
    chk("t6 c0_id_request", o_c0_id_request, 4'h0);
    chk("t6 c1_id_request", o_c1_id_request, 4'h8);
    rst = 0;
    tick();
    chk("t6 stays idle", o_mem_enable, 1'b0);
    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      rst = $urandom_range(299) == 0;
      i_c0_enable = $urandom_range(2) == 0;
      i_c1_enable = $urandom_range(2) == 0;
      i_c0_type = 1'($urandom_range(1));
      i_c1_type = 1'($urandom_range(1));
      i_c0_addr = $urandom & ~32'hF;
      i_c1_addr = $urandom & ~32'hF;
      i_c0_data = {$urandom, $urandom, $urandom, $urandom};
      i_c1_data = {$urandom, $urandom, $urandom, $urandom};
      i_mem_ready = ((k / 400) % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
      i_mem_enable = 1'($urandom_range(1));
      i_mem_id = 4'($urandom_range(15));
      i_mem_data = {$urandom, $urandom, $urandom, $urandom};
      i_c0_mem_ack = 1'($urandom_range(1));
      i_c1_mem_ack = 1'($urandom_range(1));
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
